// File: rtl/quant_accum_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quant_accum_ctrl_pkg                                                 |
// | Shared widths and FSM state encoding for the quantizing accumulator. |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package quant_accum_ctrl_pkg;

    localparam int c_data_w_dflt = 4;
    localparam int c_cnt_w_dflt  = 4;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_st_idle,
        ST_ACCUM = c_st_accum,
        ST_DONE  = c_st_done
    } state_t;

endpackage
`default_nettype wire

// File: rtl/quant_add_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quant_add_stage                                                      |
// | Combinational acc+aligned add with one-bit shift-right on carry.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module quant_add_stage
    import quant_accum_ctrl_pkg::*;
#(
    parameter int DATA_W = c_data_w_dflt
) (
    input  logic [DATA_W-1:0] i_acc,
    input  logic [DATA_W-1:0] i_aligned,
    output logic [DATA_W-1:0] o_acc_nxt,
    output logic              o_carry
);

    logic [DATA_W:0] w_sum;

    assign w_sum   = {1'b0, i_acc} + {1'b0, i_aligned};
    assign o_carry = w_sum[DATA_W];
    // On carry the top bit is 1, so the upper DATA_W bits are the halved sum.
    assign o_acc_nxt = o_carry ? w_sum[DATA_W:1] : w_sum[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/quant_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | quant_accum_ctrl                                                     |
// | Accumulates len operands into a mantissa/exponent pair.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module quant_accum_ctrl
    import quant_accum_ctrl_pkg::*;
#(
    parameter int DATA_W = c_data_w_dflt,
    parameter int CNT_W  = c_cnt_w_dflt
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  out_exp,
    input  logic              out_ready,
    output logic              busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_exp;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_load;
    logic                w_xfer;
    logic [DATA_W-1:0]   w_aligned;
    logic [DATA_W-1:0]   w_acc_nxt;
    logic                w_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_xfer      = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    w_xfer = 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operands are scaled down to the accumulator's current exponent.
    assign w_aligned = (32'(r_exp) >= DATA_W) ? '0 : (in_data >> r_exp);

    quant_add_stage #(
        .DATA_W (DATA_W)
    ) u_add (
        .i_acc     (r_acc),
        .i_aligned (w_aligned),
        .o_acc_nxt (w_acc_nxt),
        .o_carry   (w_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_exp <= '0;
            r_cnt <= '0;
        end else if (w_load) begin
            r_acc <= '0;
            r_exp <= '0;
            r_cnt <= len;
        end else if (w_xfer) begin
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt - 1'b1;
            if (w_carry && (r_exp != {CNT_W{1'b1}})) begin
                r_exp <= r_exp + 1'b1;
            end
        end
    end

    assign out_data = r_acc;
    assign out_exp  = r_exp;

endmodule
`default_nettype wire

// File: tb/tb_quant_accum_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_quant_accum_ctrl                                                  |
// | Scoreboard bench: directed cases plus randomized accumulations.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_quant_accum_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] len;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic [3:0] out_exp;
    logic       out_ready;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int rdy_mode = 2;   // 0 random, 1 held low, 2 held high
    int exp_q_data[$];
    int exp_q_exp[$];
    int opd[16];
    int last_d = 0;
    int last_e = 0;

    quant_accum_ctrl #(.DATA_W(4), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_exp   (out_exp),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: mantissa/exponent accumulation with plain integer arithmetic.
    function automatic void model(input int n, output int r, output int e);
        int acc = 0;
        int ex  = 0;
        int a;
        int s;
        for (int i = 0; i < n; i++) begin
            a = (ex >= 4) ? 0 : opd[i] / (1 << ex);
            s = acc + a;
            if (s > 15) begin
                acc = s / 2;
                if (ex < 15) ex++;
            end else begin
                acc = s;
            end
        end
        r = acc;
        e = ex;
    endfunction

    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: result must match the scoreboard head for every cycle it is shown.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (exp_q_data.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    chk("out_data", int'(out_data), exp_q_data[0]);
                    chk("out_exp", int'(out_exp), exp_q_exp[0]);
                    if (out_ready) begin
                        void'(exp_q_data.pop_front());
                        void'(exp_q_exp.pop_front());
                    end
                end
            end
        end
    end

    task automatic run_op(input int n, input bit gaps);
        int r;
        int e;
        int i = 0;
        int cyc = 0;
        bit v;
        model(n, r, e);
        exp_q_data.push_back(r);
        exp_q_exp.push_back(e);
        last_d = r;
        last_e = e;
        start = 1'b1;
        len   = 4'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        while (i < n && cyc < 200) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            in_data  = v ? 4'(opd[i]) : 4'($urandom_range(0, 15));
            chk("in_ready_accum", int'(in_ready), 1);
            @(posedge clk);
            #1;
            if (v) i++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("accum_timeout", int'(i < n), 0);
        chk("in_ready_done", int'(in_ready), 0);
        chk("valid_latency", int'(out_valid), 1);
    endtask

    task automatic wait_idle();
        int cyc = 0;
        while (busy && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("idle_timeout", int'(busy), 0);
        chk("idle_out_valid", int'(out_valid), 0);
        chk("idle_retain_data", int'(out_data), last_d);
        chk("idle_retain_exp", int'(out_exp), last_e);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = 4'd0;
        in_valid = 1'b0;
        in_data  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_exp", int'(out_exp), 0);
        chk("rst_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        opd[0] = 3; opd[1] = 4;
        run_op(2, 1'b0);
        wait_idle();

        opd[0] = 9; opd[1] = 9;
        run_op(2, 1'b0);
        wait_idle();

        opd[0] = 9; opd[1] = 9; opd[2] = 6;
        run_op(3, 1'b0);
        wait_idle();

        run_op(0, 1'b0);
        wait_idle();

        // Stall in DONE, pulse start, then release.
        rdy_mode = 1;
        opd[0] = 3; opd[1] = 4;
        run_op(2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            len   = 4'd5;
            @(posedge clk);
            #1;
            chk("stall_out_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        start = 1'b0;
        rdy_mode = 2;
        wait_idle();

        // Abort after the first of three operands.
        start = 1'b1;
        len   = 4'd3;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 4'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("abort_in_ready", int'(in_ready), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_out_data", int'(out_data), 0);
        chk("abort_out_exp", int'(out_exp), 0);
        chk("abort_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        opd[0] = 5;
        run_op(1, 1'b0);
        wait_idle();

        rdy_mode = 0;
        for (int t = 0; t < 40; t++) begin
            int n;
            n = $urandom_range(0, 15);
            for (int k = 0; k < 16; k++) opd[k] = $urandom_range(0, 15);
            run_op(n, 1'b1);
            wait_idle();
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", exp_q_data.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/quant_accum_ctrl.md
QUANT_ACCUM_CTRL -- requirements
Module: quant_accum_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 4: operand, accumulator and result width.
REQ-002 SHALL have parameter CNT_W, default 4: width of the operand-count and exponent fields.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 start  in  1  begin a new accumulation; sampled only in IDLE.
REQ-007 len  in  CNT_W  number of operands to accumulate (0..15); sampled with start.
REQ-008 in_valid  in  1  operand-present qualifier.
REQ-009 in_data  in  DATA_W  unsigned operand.
REQ-010 in_ready  out  1  block accepts the operand this cycle.
REQ-011 out_valid  out  1  result present.
REQ-012 out_data  out  DATA_W  quantized accumulator mantissa.
REQ-013 out_exp  out  CNT_W  count of quantization shifts applied; value = out_data * 2^out_exp.
REQ-014 out_ready  in  1  downstream consumes the result.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-017 IDLE->ACCUM on start with len!=0: acc=0, exp=0, cnt=len.
REQ-018 IDLE->DONE on start with len==0: acc=0, exp=0; out_valid asserts the next cycle.
REQ-019 SHALL ignore start in ACCUM and DONE.
REQ-020 in_ready=1 only in ACCUM; an operand transfers on in_valid && in_ready.
REQ-021 On a transfer, aligned = in_data >> exp; aligned = 0 when exp >= DATA_W.
REQ-022 sum = acc + aligned, computed DATA_W+1 bits wide; carry = sum[DATA_W].
REQ-023 carry==0: acc <= sum[DATA_W-1:0], exp unchanged.
REQ-024 carry==1: acc <= {1'b1, sum[DATA_W-1:1]}, exp <= exp+1, saturating at 2^CNT_W-1.
REQ-025 Each transfer decrements cnt; the transfer that takes cnt to 0 moves the FSM to DONE.
REQ-026 Throughput one operand per cycle; out_valid asserts the cycle after the final transfer.
REQ-027 in_valid low in ACCUM: hold all state.
REQ-028 DONE: out_valid=1; out_data=acc, out_exp=exp, both stable until out_ready.
REQ-029 DONE with out_ready=1: return to IDLE next cycle, out_valid deasserts; no new start in that same cycle.
REQ-030 out_data/out_exp SHALL retain the last result in IDLE; out_valid=0 outside DONE.

Reset
REQ-031 rst_n low SHALL immediately force: state=IDLE, acc=0, exp=0, cnt=0, in_ready=0, out_valid=0, out_data=0, out_exp=0, busy=0.
REQ-032 Reset in any state SHALL abort the operation and discard partial results.
REQ-033 Operation SHALL resume on the first rising clk edge after rst_n deasserts.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding and the DATA_W/CNT_W defaults.
REQ-035 Datapath SHALL be the sub-module quant_add_stage: combinational add of acc+aligned plus carry-driven shift-right quantization.
REQ-036 quant_accum_ctrl SHALL contain only the FSM, counters, alignment shifter and registers.

Verification
REQ-037 len=2, data 3,4 -> out_data=7, out_exp=0, out_valid one cycle after the 2nd transfer.
REQ-038 len=2, data 9,9 -> 18 overflows -> out_data=9 (4'b1001), out_exp=1.
REQ-039 len=3, data 9,9,6 -> third operand aligned to 3; 9+3=12 -> out_data=12, out_exp=1.
REQ-040 len=0 -> out_valid the cycle after start, out_data=0, out_exp=0, no in_ready pulse.
REQ-041 Hold out_ready=0 for 3 cycles in DONE and pulse start -> result stable, start ignored, IDLE after out_ready.
REQ-042 Assert rst_n=0 after the 1st of 3 operands -> all outputs 0 at once; new start with len=1, data 5 -> out 5, exp 0.
